// File: rtl/pixel_adjust_pkg.sv
// Shared constants and arithmetic helpers for the per-channel brightness/contrast pipeline.
package pixel_adjust_pkg;

  localparam int MODE_BRIGHT   = 0;
  localparam int MODE_CONTRAST = 1;

  function automatic int MID(input int dw);
    return 1 << (dw - 1);
  endfunction

  // Half an LSB of the gain fraction, added before the arithmetic shift to round half up.
  function automatic int round_const(input int frac);
    return (frac > 0) ? (1 << (frac - 1)) : 0;
  endfunction

  function automatic logic signed [63:0] clamp_val(input logic signed [63:0] z, input int dw);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< dw) - 64'sd1;
    if (z < 64'sd0) return '0;
    if (z > hi) return hi;
    return z;
  endfunction

endpackage

// File: rtl/pixel_adjust_lane.sv
// One channel of the adjust pipeline: S1 offset, S2 contrast about mid-grey, S3 clamp.
module pixel_adjust_lane
  import pixel_adjust_pkg::*;
#(
  parameter int DW   = 8,
  parameter int FRAC = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DW-1:0]      x,
  input  logic signed [DW:0] offset,
  input  logic               bright_en,
  input  logic [DW-1:0]      gain,
  input  logic               contrast_en,
  output logic [DW-1:0]      y,
  output logic               sat
);

  localparam int YW = DW + 2;
  localparam int PW = 2 * DW + 3;
  localparam logic signed [PW-1:0] MID_P = PW'(MID(DW));
  localparam logic signed [PW-1:0] RND_P = PW'(round_const(FRAC));

  logic signed [YW-1:0] s1_y_d;
  logic signed [YW-1:0] s1_y;
  logic [DW-1:0]        s1_gain;
  logic                 s1_contrast;
  logic signed [PW-1:0] s1_y_ext;
  logic signed [PW-1:0] s2_prod;
  logic signed [PW-1:0] s2_z_d;
  logic signed [PW-1:0] s2_z;
  logic signed [63:0]   s3_z_ext;
  logic signed [63:0]   s3_clamped;

  always_comb begin
    s1_y_d = $signed({2'b00, x});
    if (bright_en) begin
      s1_y_d = $signed({2'b00, x}) + $signed({offset[DW], offset});
    end
  end

  // Gain and contrast enable ride along with the sample so S2 uses this beat's config.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_y        <= '0;
      s1_gain     <= '0;
      s1_contrast <= 1'b0;
    end else if (en) begin
      s1_y        <= s1_y_d;
      s1_gain     <= gain;
      s1_contrast <= contrast_en;
    end
  end

  always_comb begin
    s1_y_ext = {{(PW-YW){s1_y[YW-1]}}, s1_y};
    s2_prod  = (s1_y_ext - MID_P) * $signed({{(PW-DW){1'b0}}, s1_gain});
    s2_z_d   = s1_y_ext;
    if (s1_contrast) begin
      s2_z_d = ((s2_prod + RND_P) >>> FRAC) + MID_P;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_z <= '0;
    end else if (en) begin
      s2_z <= s2_z_d;
    end
  end

  always_comb begin
    s3_z_ext   = {{(64-PW){s2_z[PW-1]}}, s2_z};
    s3_clamped = clamp_val(s3_z_ext, DW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      y   <= s3_clamped[DW-1:0];
      sat <= (s3_clamped != s3_z_ext);
    end
  end

endmodule

// File: rtl/pixel_adjust_pipe.sv
// N-channel brightness/contrast pipeline with valid/ready flow control, per-frame
// config shadowing and per-frame saturation statistics.
module pixel_adjust_pipe
  import pixel_adjust_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CH   = 3,
  parameter int FRAC = 6,
  parameter int CW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [CH*DW-1:0]   s_data,
  input  logic               s_sof,
  input  logic               s_eol,
  input  logic signed [DW:0] cfg_offset,
  input  logic [DW-1:0]      cfg_gain,
  input  logic [1:0]         cfg_mode,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CH*DW-1:0]   m_data,
  output logic               m_sof,
  output logic               m_eol,
  output logic [CW-1:0]      frame_sat,
  output logic               frame_sat_valid
);

  localparam logic [DW-1:0] GAIN_ONE = DW'(1 << FRAC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic               en;
  logic               accept;
  logic               out_beat;
  logic signed [DW:0] sh_offset;
  logic [DW-1:0]      sh_gain;
  logic [1:0]         sh_mode;
  logic signed [DW:0] eff_offset;
  logic [DW-1:0]      eff_gain;
  logic [1:0]         eff_mode;
  logic               s1_valid;
  logic               s2_valid;
  logic               s1_sof;
  logic               s2_sof;
  logic               s1_eol;
  logic               s2_eol;
  logic [CH-1:0]      lane_sat;
  logic               sat_any;
  logic [CW-1:0]      sat_cnt;
  logic               have_frame;

  assign en       = !m_valid || m_ready;
  assign s_ready  = en;
  assign accept   = s_valid && en;
  assign out_beat = m_valid && m_ready;
  assign sat_any  = |lane_sat;

  // An SOF beat uses the live config directly so the new frame starts on the new values.
  always_comb begin
    eff_offset = sh_offset;
    eff_gain   = sh_gain;
    eff_mode   = sh_mode;
    if (s_sof) begin
      eff_offset = cfg_offset;
      eff_gain   = cfg_gain;
      eff_mode   = cfg_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_offset <= '0;
      sh_gain   <= GAIN_ONE;
      sh_mode   <= 2'b00;
    end else if (accept && s_sof) begin
      sh_offset <= cfg_offset;
      sh_gain   <= cfg_gain;
      sh_mode   <= cfg_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      m_valid  <= 1'b0;
      s1_sof   <= 1'b0;
      s2_sof   <= 1'b0;
      m_sof    <= 1'b0;
      s1_eol   <= 1'b0;
      s2_eol   <= 1'b0;
      m_eol    <= 1'b0;
    end else if (en) begin
      s1_valid <= s_valid;
      s2_valid <= s1_valid;
      m_valid  <= s2_valid;
      s1_sof   <= s_valid && s_sof;
      s2_sof   <= s1_sof;
      m_sof    <= s2_sof;
      s1_eol   <= s_valid && s_eol;
      s2_eol   <= s1_eol;
      m_eol    <= s2_eol;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    pixel_adjust_lane #(
      .DW   (DW),
      .FRAC (FRAC)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .x           (s_data[c*DW +: DW]),
      .offset      (eff_offset),
      .bright_en   (eff_mode[MODE_BRIGHT]),
      .gain        (eff_gain),
      .contrast_en (eff_mode[MODE_CONTRAST]),
      .y           (m_data[c*DW +: DW]),
      .sat         (lane_sat[c])
    );
  end

  // The count is reported at the next frame's first output beat, never at end of line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt         <= '0;
      have_frame      <= 1'b0;
      frame_sat       <= '0;
      frame_sat_valid <= 1'b0;
    end else begin
      frame_sat_valid <= 1'b0;
      if (out_beat) begin
        if (m_sof) begin
          if (have_frame) begin
            frame_sat       <= sat_cnt;
            frame_sat_valid <= 1'b1;
          end
          have_frame <= 1'b1;
          sat_cnt    <= {{(CW-1){1'b0}}, sat_any};
        end else if (sat_any && (sat_cnt != CNT_MAX)) begin
          sat_cnt <= sat_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_adjust_pipe.sv
// Directed-vector and backpressure bench for pixel_adjust_pipe (DW=8, CH=3, FRAC=6).
module tb_pixel_adjust_pipe;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int FRAC = 6;
  localparam int CW = 32;
  localparam int W = 16;
  localparam int H = 4;
  localparam int NF = 3;
  localparam int TOTAL = W * H * NF;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [CH*DW-1:0]   s_data;
  logic               s_sof;
  logic               s_eol;
  logic signed [DW:0] cfg_offset;
  logic [DW-1:0]      cfg_gain;
  logic [1:0]         cfg_mode;
  logic               m_valid;
  logic               m_ready;
  logic [CH*DW-1:0]   m_data;
  logic               m_sof;
  logic               m_eol;
  logic [CW-1:0]      frame_sat;
  logic               frame_sat_valid;

  always #5 clk = ~clk;

  pixel_adjust_pipe #(
    .DW   (DW),
    .CH   (CH),
    .FRAC (FRAC),
    .CW   (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_sof           (s_sof),
    .s_eol           (s_eol),
    .cfg_offset      (cfg_offset),
    .cfg_gain        (cfg_gain),
    .cfg_mode        (cfg_mode),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_sof           (m_sof),
    .m_eol           (m_eol),
    .frame_sat       (frame_sat),
    .frame_sat_valid (frame_sat_valid)
  );

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [1:0]  mode;
    logic [8:0]  offset;
    logic [7:0]  gain;
    logic [23:0] pix;
    logic [23:0] expd;
    logic        sat;
  } vec_t;

  vec_t tbl [12];
  int   testsRun = 0;
  int   testsFailed = 0;
  bit   hasFrame;
  int   satCnt;

  function automatic logic [23:0] px(input int c0, input int c1, input int c2);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic vec_t mk(input bit sof, input bit eol, input int mode, input int off,
                              input int gain, input logic [23:0] pix, input logic [23:0] expd,
                              input bit sat);
    vec_t v;
    v.sof    = sof;
    v.eol    = eol;
    v.mode   = 2'(mode);
    v.offset = 9'(off);
    v.gain   = 8'(gain);
    v.pix    = pix;
    v.expd   = expd;
    v.sat    = sat;
    return v;
  endfunction

  // Reference arithmetic: returns {sat, pixel}.
  function automatic logic [24:0] modelPix(input logic [23:0] pix, input int off, input int gain,
                                           input logic [1:0] mode);
    logic [24:0] r;
    int x, y, z;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      x = int'(pix[c*8 +: 8]);
      y = mode[0] ? x + off : x;
      z = mode[1] ? ((((y - 128) * gain + 32) >>> 6) + 128) : y;
      if (z < 0) begin
        z = 0;
        r[24] = 1'b1;
      end else if (z > 255) begin
        z = 255;
        r[24] = 1'b1;
      end
      r[c*8 +: 8] = 8'(z);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    s_valid    = 1'b1;
    s_sof      = v.sof;
    s_eol      = v.eol;
    s_data     = v.pix;
    cfg_mode   = v.mode;
    cfg_offset = v.offset;
    cfg_gain   = v.gain;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int cyc;
    bit expPulse;
    int expVal;
    applyStimulus(v);
    cyc = 1;
    while (!m_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, 3);
    if (m_valid) begin
      checkOutput({tag, " data"}, m_data, v.expd);
      checkOutput({tag, " sof"}, m_sof, v.sof);
      checkOutput({tag, " eol"}, m_eol, v.eol);
    end
    expPulse = v.sof && hasFrame;
    expVal   = satCnt;
    if (v.sof) begin
      hasFrame = 1'b1;
      satCnt   = int'(v.sat);
    end else begin
      satCnt += int'(v.sat);
    end
    @(negedge clk);
    checkOutput({tag, " pulse"}, frame_sat_valid, expPulse);
    if (expPulse) checkOutput({tag, " frame_sat"}, frame_sat, expVal);
  endtask

  task automatic runResetTest();
    s_valid    = 1'b1;
    s_sof      = 1'b0;
    s_data     = px(10, 20, 30);
    cfg_mode   = 2'd1;
    cfg_offset = 9'sd50;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    checkOutput("rst inflight m_valid", m_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst m_valid", m_valid, 0);
    checkOutput("rst m_data", m_data, 0);
    checkOutput("rst frame_sat", frame_sat, 0);
    checkOutput("rst frame_sat_valid", frame_sat_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post-rst drained", m_valid, 0);
    end
    hasFrame = 1'b0;
    satCnt   = 0;
    runVector(mk(0, 0, 1, 50, 64, px(10, 20, 30), px(10, 20, 30), 0), "rst shadow default");
    runVector(mk(1, 0, 0, 0, 64, px(5, 6, 7), px(5, 6, 7), 0), "rst first sof");
    runVector(mk(1, 1, 1, 100, 64, px(200, 0, 0), px(255, 100, 100), 1), "rst second sof");
  endtask

  task automatic runBackpressure();
    int sent, recv, cyc, pulses, cnt, f, p;
    bit prevStall, hasF;
    logic [23:0] prevData, curPix;
    logic prevSof, prevEol;
    logic [24:0] mp;
    logic [26:0] e;
    logic [26:0] expQ [$];
    int pulseQ [$];
    int offs [NF];
    int gains [NF];
    logic [1:0] modes [NF];
    offs[0] = 20;  gains[0] = 80;  modes[0] = 2'd3;
    offs[1] = -40; gains[1] = 64;  modes[1] = 2'd1;
    offs[2] = 0;   gains[2] = 100; modes[2] = 2'd2;
    sent = 0; recv = 0; cyc = 0; pulses = 0; cnt = 0;
    prevStall = 1'b0; hasF = 1'b0;
    prevData = '0; prevSof = 1'b0; prevEol = 1'b0;
    curPix = 24'($urandom);
    while (recv < TOTAL && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (frame_sat_valid) begin
        pulses++;
        if (pulseQ.size() == 0) checkOutput("bp spurious pulse", frame_sat_valid, 0);
        else checkOutput("bp frame_sat", frame_sat, pulseQ.pop_front());
      end
      if (prevStall) begin
        checkOutput("bp stall valid", m_valid, 1);
        checkOutput("bp stall data", m_data, prevData);
        checkOutput("bp stall sof", m_sof, prevSof);
        checkOutput("bp stall eol", m_eol, prevEol);
      end
      m_ready = ($urandom_range(0, 9) < 3);
      f = 0;
      if (sent < TOTAL) begin
        f = sent / (W * H);
        p = sent % (W * H);
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = curPix;
        s_sof   = (p == 0);
        s_eol   = ((p % W) == W - 1);
        if (s_sof) begin
          cfg_offset = 9'(offs[f]);
          cfg_gain   = 8'(gains[f]);
          cfg_mode   = modes[f];
        end else begin
          cfg_offset = 9'($urandom);
          cfg_gain   = 8'($urandom);
          cfg_mode   = 2'($urandom);
        end
      end else begin
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
      end
      #1;
      if (s_valid && s_ready) begin
        mp = modelPix(curPix, offs[f], gains[f], modes[f]);
        expQ.push_back({mp[24], s_sof, s_eol, mp[23:0]});
        sent++;
        curPix = 24'($urandom);
      end
      if (m_valid && m_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("bp extra beat", m_valid, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("bp data", m_data, e[23:0]);
          checkOutput("bp sof", m_sof, e[25]);
          checkOutput("bp eol", m_eol, e[24]);
          if (e[25]) begin
            if (hasF) pulseQ.push_back(cnt);
            hasF = 1'b1;
            cnt  = int'(e[26]);
          end else begin
            cnt += int'(e[26]);
          end
        end
        recv++;
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
      prevSof   = m_sof;
      prevEol   = m_eol;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    if (frame_sat_valid) begin
      pulses++;
      if (pulseQ.size() == 0) checkOutput("bp spurious pulse", frame_sat_valid, 0);
      else checkOutput("bp frame_sat", frame_sat, pulseQ.pop_front());
    end
    checkOutput("bp beats received", recv, TOTAL);
    checkOutput("bp pulses", pulses, NF - 1);
    checkOutput("bp pending pulses", pulseQ.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = mk(1, 0, 0, 0,   64,  px(100, 150, 200), px(100, 150, 200), 0);
    tbl[1]  = mk(0, 1, 0, 0,   64,  px(0, 255, 128),   px(0, 255, 128),   0);
    tbl[2]  = mk(1, 0, 1, 72,  64,  px(100, 150, 200), px(172, 222, 255), 1);
    tbl[3]  = mk(0, 1, 1, -78, 64,  px(255, 255, 255), px(255, 255, 255), 1);
    tbl[4]  = mk(1, 0, 1, -78, 64,  px(255, 255, 255), px(177, 177, 177), 0);
    tbl[5]  = mk(1, 0, 2, 0,   128, px(100, 150, 200), px(72, 172, 255),  1);
    tbl[6]  = mk(1, 0, 2, 0,   96,  px(129, 127, 0),   px(130, 127, 0),   1);
    tbl[7]  = mk(1, 0, 1, 5,   64,  px(10, 20, 30),    px(15, 25, 35),    0);
    tbl[8]  = mk(0, 1, 0, 50,  64,  px(10, 20, 30),    px(15, 25, 35),    0);
    tbl[9]  = mk(1, 0, 1, 50,  64,  px(10, 20, 30),    px(60, 70, 80),    0);
    tbl[10] = mk(1, 0, 3, 10,  128, px(100, 150, 20),  px(92, 192, 0),    1);
    tbl[11] = mk(1, 1, 1, 1,   64,  px(1, 2, 3),       px(2, 3, 4),       0);

    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    s_sof      = 1'b0;
    s_eol      = 1'b0;
    cfg_offset = '0;
    cfg_gain   = 8'd64;
    cfg_mode   = 2'd0;
    m_ready    = 1'b0;
    hasFrame   = 1'b0;
    satCnt     = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset m_valid", m_valid, 0);
    checkOutput("reset m_data", m_data, 0);
    checkOutput("reset m_sof", m_sof, 0);
    checkOutput("reset m_eol", m_eol, 0);
    checkOutput("reset frame_sat", frame_sat, 0);
    checkOutput("reset frame_sat_valid", frame_sat_valid, 0);
    checkOutput("reset s_ready", s_ready, 1);
    rst     = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      runVector(tbl[i], $sformatf("vec%0d", i));
    end

    runResetTest();

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runBackpressure();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pixel_adjust_pipe.md
# pixel_adjust_pipe

Parametrised per-channel brightness/contrast adjust pipeline for the video datapath. Generalises the single-pixel RGB brightness stage to N channels of configurable width. Adds signed offset plus fixed-point contrast gain about mid-grey, valid/ready backpressure, frame-synchronous configuration shadowing and per-frame saturation statistics. It sits between the pixel unpacker and the output formatter.

## Interface
- DW, 8: bits per channel sample.
- CH, 3: channels per pixel, packed channel 0 in LSBs.
- FRAC, 6: fractional bits of contrast gain; gain 2^FRAC = 1.0.
- CW, 32: saturation counter width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  CH*DW  input pixel.
- s_sof  in  1  first pixel of frame.
- s_eol  in  1  last pixel of line (sideband, passed through).
- cfg_offset  in  DW+1  signed brightness offset.
- cfg_gain  in  DW  unsigned contrast gain, FRAC fractional bits.
- cfg_mode  in  2  bit0 brightness enable, bit1 contrast enable.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  CH*DW  adjusted pixel.
- m_sof, m_eol  out  1  sideband aligned with m_data.
- frame_sat  out  CW  saturated-pixel count of the last completed frame.
- frame_sat_valid  out  1  one-cycle pulse when frame_sat updates.

## Operation
- Shadow config (offset, gain, mode) loads on an accepted beat with s_sof=1. That beat and all following beats use the new values. Between SOFs, cfg_* changes are ignored.
- Shadow reset values: offset 0, gain 2^FRAC, mode 0 (bypass).
- Shadow values travel down the pipe with each beat, so an SOF in flight never retimes older pixels.
- Per channel, with MID = 2^(DW-1):
  - S1 brightness: y = x + offset if mode[0], else y = x. Signed, DW+2 bits, no clamp.
  - S2 contrast: if mode[1], z = ((y-MID)*gain + 2^(FRAC-1)) >>> FRAC, then + MID; else z = y.
  - S2 keeps full precision: product is 2*DW+3 bits signed, and the shift is arithmetic (round half toward +inf).
  - S3 clamp: z<0 gives 0; z>2^DW-1 gives 2^DW-1.
- Saturation is flagged if any channel clipped in S3.
- Saturation counter:
  - On an output beat with m_sof, the counter loads 0 plus that beat's flag.
  - Otherwise the counter increments by one per flagged output beat.
  - On an output beat with m_eol and the next accepted beat being m_sof, the count is not latched. frame_sat latches only on an output beat with m_sof where a previous frame exists (not the first frame after reset). The latched value is the pre-clear count, and frame_sat_valid pulses.

## Timing
- Latency is 3 cycles, s_data to m_data, when unstalled. Throughput is 1 pixel/clk.
- Pipeline enable: en = !m_valid || m_ready.
  - All stages advance only when en=1.
  - s_ready = en (combinational from m_ready).
- Stall: while m_valid && !m_ready, m_data, m_sof and m_eol are held stable and no input is accepted.
- Bubbles propagate as invalid stages; internal valids shift with en.
- Reset values: m_valid 0, m_data 0, m_sof 0, m_eol 0, frame_sat 0, frame_sat_valid 0, all internal valids 0, shadows at defaults, counter 0.
- rst mid-frame drops every in-flight pixel. The first post-reset frame gives no frame_sat pulse at its start.
- Simultaneous s_sof accept and m_sof output: the input side loads new shadows while the output side latches and clears the counter. These are independent.
- Counter wrap: saturates at 2^CW-1 (no wrap).

## Structure
- pixel_adjust_pkg holds:
  - MODE_BRIGHT and MODE_CONTRAST bit indices.
  - A MID(DW) function.
  - Rounding-constant and clamp functions.
- Sub-module pixel_adjust_lane implements the S1–S3 arithmetic for one channel. It exposes sat and takes en. It is generated CH times.
- Top level holds the handshake, shadows, sideband pipe and statistics.

## Test plan
All cases use DW=8, CH=3, FRAC=6.
- Bypass: mode 0, pixel (100,150,200) → (100,150,200) after 3 clk; frame_sat counts 0.
- Brightness: SOF with mode 1, offset +72 on (100,150,200) → (172,222,255), sat flag set. Offset −78 on (255,255,255) → (177,177,177).
- Contrast: mode 2, gain 128 on (100,150,200) → (72,172,255). Gain 96 on (129,127,0) → (130,127,0), which checks rounding and clamp-to-0.
- Shadowing: change cfg_offset mid-frame; pixels stay on the old offset until the next accepted s_sof. The new-SOF pixel uses the new value.
- Backpressure: random m_ready at 30% duty over a 16×4 frame.
  - No loss, duplication or reordering.
  - m_data is stable during stalls.
  - frame_sat matches the reference model count, with exactly one frame_sat_valid pulse per frame boundary.
- Reset mid-frame: assert rst with 3 pixels in flight → m_valid=0 the next cycle, shadows at defaults, no frame_sat pulse at the first post-reset SOF.
